// File: rtl/regfile_2r1w.sv
// Architectural integer register file: 32 x 64-bit, two combinational read ports,
// one synchronous write port, XZR hard-wired to zero, same-cycle write-to-read bypass.
module regfile_2r1w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_a,
    output logic [WIDTH-1:0]         rd_data_b,
    input  logic                     reg_write,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);

    logic [NREGS-1:0] wr_en;
    logic [WIDTH-1:0] reg_val [NREGS];

    // Address compare only happens under reg_write, so an unknown wr_addr on an
    // idle cycle can never raise an enable.
    always_comb begin
        wr_en = '0;
        if (reg_write) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_addr == AW'(i)) begin
                    wr_en[i] = 1'b1;
                end
            end
        end
        wr_en[ZERO_REG] = 1'b0;
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign reg_val[i] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;

            always_comb begin
                data_d = data_q;
                if (wr_en[i]) begin
                    data_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign reg_val[i] = data_q;
        end
    end

    always_comb begin
        rd_data_a = reg_val[rd_addr_a];
        if (rd_addr_a == ZeroAddr) begin
            rd_data_a = '0;
        end else if (reg_write && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = reg_val[rd_addr_b];
        if (rd_addr_b == ZeroAddr) begin
            rd_data_b = '0;
        end else if (reg_write && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule
